// File: rtl/i2s_pkg.sv
// Shared constants and state encoding for the I2S microphone receivers.
// SLOT_W sizes the slot counter that wraps once per frame.
package i2s_pkg;

    localparam int SLOTS_PER_CH = 32;
    localparam int FRAME_SLOTS  = 64;
    localparam int MIC_WORD_W   = 24;
    localparam int SLOT_W       = $clog2(FRAME_SLOTS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

endpackage

// File: rtl/i2s_clkgen.sv
// SCK/WS generator: half-phase counter, slot counter and the bit-timing strobes.
// All state is held at zero whenever active is low, so frames restart at slot 0.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active,
    output logic              mic_sck,
    output logic              mic_ws,
    output logic [SLOT_W-1:0] sl,
    output logic              capture,
    output logic              fall,
    output logic              frame_wrap
);

    localparam int HC_W = $clog2(CLK_DIV);

    logic [HC_W-1:0]   hc_reg;
    logic              sck_reg;
    logic [SLOT_W-1:0] sl_reg;
    logic              half_end;

    assign half_end = (hc_reg == HC_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || !active) begin
            hc_reg  <= '0;
            sck_reg <= 1'b0;
            sl_reg  <= '0;
        end else if (half_end) begin
            hc_reg  <= '0;
            sck_reg <= ~sck_reg;
            if (sck_reg) begin
                sl_reg <= sl_reg + 1'b1;
            end
        end else begin
            hc_reg <= hc_reg + 1'b1;
        end
    end

    // The last clock of the high phase is both the sampling point and the falling edge.
    assign fall       = active && sck_reg && half_end;
    assign capture    = fall;
    assign frame_wrap = fall && (sl_reg == SLOT_W'(FRAME_SLOTS - 1));

    assign mic_sck = sck_reg;
    assign mic_ws  = sl_reg[SLOT_W-1];
    assign sl      = sl_reg;

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for one MEMS microphone: clocking, left-slot deserializer,
// warm-up discard and a valid/ready output stage with a sticky overrun flag.
module i2s_mic_rx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV       = 16,
    parameter int OUT_W         = 16,
    parameter int WARMUP_FRAMES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mic_da,
    output logic             mic_sck,
    output logic             mic_ws,
    output logic             mic_lr,
    output logic [OUT_W-1:0] sample,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun
);

    localparam int FC_W = 16;

    state_t            state_reg;
    state_t            state_next;
    logic [1:0]        sync_reg;
    logic              mic_da_s;
    logic              active;
    logic [SLOT_W-1:0] sl;
    logic              capture;
    logic              fall;
    logic              frame_wrap;
    logic [FC_W-1:0]   frame_cnt_reg;
    logic              last_warmup;
    logic [OUT_W-1:0]  shift_reg;
    logic [OUT_W-1:0]  word_next;
    logic              in_word;
    logic              complete;
    logic [OUT_W-1:0]  sample_reg;
    logic              valid_reg;
    logic              overrun_reg;

    // mic_da is asynchronous to clk; only mic_da_s is used downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], mic_da};
        end
    end
    assign mic_da_s = sync_reg[1];

    assign active = en && (state_reg != IDLE);

    i2s_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (active),
        .mic_sck   (mic_sck),
        .mic_ws    (mic_ws),
        .sl        (sl),
        .capture   (capture),
        .fall      (fall),
        .frame_wrap(frame_wrap)
    );

    assign last_warmup = (frame_cnt_reg == FC_W'(WARMUP_FRAMES - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next = (WARMUP_FRAMES == 0) ? RUN : WARMUP;
                end
            end
            WARMUP: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (frame_wrap && last_warmup) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !active) begin
            frame_cnt_reg <= '0;
        end else if (state_reg == WARMUP && frame_wrap) begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
    end

    // Slot 0 is the I2S delay bit; slots 1..OUT_W carry the kept MSBs.
    assign in_word   = (sl != '0) && (sl <= SLOT_W'(OUT_W));
    assign complete  = capture && (sl == SLOT_W'(OUT_W));
    assign word_next = (shift_reg << 1) | OUT_W'(mic_da_s);

    always_ff @(posedge clk) begin
        if (!rst_n || !active) begin
            shift_reg <= '0;
        end else if (fall && sl == '0) begin
            shift_reg <= '0;
        end else if (capture && in_word) begin
            shift_reg <= word_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !active) begin
            sample_reg  <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else if (complete && state_reg == RUN) begin
            if (!valid_reg || sample_ready) begin
                sample_reg <= word_next;
                valid_reg  <= 1'b1;
            end else begin
                overrun_reg <= 1'b1;
            end
        end else if (valid_reg && sample_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign mic_lr       = 1'b0;
    assign sample       = sample_reg;
    assign sample_valid = valid_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Directed bench for i2s_mic_rx with a behavioural MEMS mic (CLK_DIV=4, one warm-up frame).
module tb_i2s_mic_rx;

    localparam int CLK_DIV       = 4;
    localparam int OUT_W         = 16;
    localparam int WARMUP_FRAMES = 1;
    localparam int FIRST_LAT     = 649;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             mic_da;
    logic             mic_sck;
    logic             mic_ws;
    logic             mic_lr;
    logic [OUT_W-1:0] sample;
    logic             sample_valid;
    logic             sample_ready;
    logic             overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    i2s_mic_rx #(
        .CLK_DIV      (CLK_DIV),
        .OUT_W        (OUT_W),
        .WARMUP_FRAMES(WARMUP_FRAMES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mic_da      (mic_da),
        .mic_sck     (mic_sck),
        .mic_ws      (mic_ws),
        .mic_lr      (mic_lr),
        .sample      (sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Behavioural mic: shifts the 24-bit word MSB-first after each SCK fall while WS=0.
    logic [23:0] mic_word;
    int          k;
    logic        prev_ws;

    always @(negedge mic_sck) begin
        #1;
        if (!en || !rst_n) begin
            k = 0;
            prev_ws = 1'b0;
            mic_da = 1'b0;
        end else begin
            if (prev_ws && !mic_ws) k = 0;
            else k = k + 1;
            prev_ws = mic_ws;
            mic_da = (!mic_ws && k >= 1 && k <= 24) ? mic_word[24-k] : 1'b0;
        end
    end

    always @(negedge en or negedge rst_n) begin
        k = 0;
        prev_ws = 1'b0;
        mic_da = 1'b0;
    end

    typedef struct {
        logic [23:0]      word;
        logic [OUT_W-1:0] exp_sample;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic wait_valid(input string name, input int bound, output int rel);
        rel = 0;
        while (!sample_valid && rel < bound) begin
            tick();
            rel++;
        end
        if (!sample_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d clk, required sample_valid=1", name, rel);
        end
    endtask

    task automatic wait_slot10(input string name);
        int n;
        n = 0;
        while (k != 10 && n < 700) begin
            tick();
            n++;
        end
        check(name, 32'(k), 32'd10);
    endtask

    initial begin
        int   rel;
        int   rise1, rise2, high_cnt, ws_rise, ws_fall, n;
        logic prev_sck, pws, coinc, stable;

        vecs[0] = '{24'h800001, 16'h8000};
        vecs[1] = '{24'h7FFFFF, 16'h7FFF};
        vecs[2] = '{24'h000000, 16'h0000};
        vecs[3] = '{24'hFFFFFF, 16'hFFFF};
        vecs[4] = '{24'h123456, 16'h1234};
        vecs[5] = '{24'h5A0FF0, 16'h5A0F};
        vecs[6] = '{24'hA5F00F, 16'hA5F0};

        rst_n = 1'b0;
        en = 1'b0;
        sample_ready = 1'b0;
        mic_word = 24'h0;
        mic_da = 1'b0;
        repeat (3) tick();
        check("rst_sck", 32'(mic_sck), 32'd0);
        check("rst_ws", 32'(mic_ws), 32'd0);
        check("rst_lr", 32'(mic_lr), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        rst_n = 1'b1;
        high_cnt = 0;
        repeat (20) begin
            tick();
            if (mic_sck) high_cnt++;
        end
        check("idle_sck_quiet", 32'(high_cnt), 32'd0);

        // Clocking and first sample after one discarded warm-up frame.
        mic_word = 24'hA5F00F;
        sample_ready = 1'b1;
        en = 1'b1;
        rel = 0; rise1 = -1; rise2 = -1; high_cnt = 0; ws_rise = -1; ws_fall = -1;
        coinc = 1'b1; prev_sck = 1'b0; pws = 1'b0;
        while (!sample_valid && rel < 1000) begin
            tick();
            rel++;
            if (mic_sck && !prev_sck) begin
                if (rise1 < 0) rise1 = rel;
                else if (rise2 < 0) rise2 = rel;
            end
            if (mic_sck && rise1 >= 0 && rise2 < 0) high_cnt++;
            if (mic_ws != pws) begin
                if (mic_ws) ws_rise = rel;
                else ws_fall = rel;
                coinc = coinc && prev_sck && !mic_sck;
            end
            prev_sck = mic_sck;
            pws = mic_ws;
        end
        check("first_sck_rise", 32'(rise1), 32'd5);
        check("sck_period", 32'(rise2 - rise1), 32'd8);
        check("sck_high_clk", 32'(high_cnt), 32'd4);
        check("ws_rise_at", 32'(ws_rise), 32'd257);
        check("ws_fall_at", 32'(ws_fall), 32'd513);
        check("ws_on_sck_fall", 32'(coinc), 32'd1);
        check("first_valid_latency", 32'(rel), 32'(FIRST_LAT));
        check("first_sample", 32'(sample), 32'h0000A5F0);
        tick();
        check("valid_one_clk", 32'(sample_valid), 32'd0);

        for (int i = 0; i < 7; i++) begin
            mic_word = vecs[i].word;
            wait_valid("vec_valid", 600, rel);
            check($sformatf("vec%0d_sample", i), 32'(sample), 32'(vecs[i].exp_sample));
            tick();
            check($sformatf("vec%0d_valid_drop", i), 32'(sample_valid), 32'd0);
        end

        // Backpressure: hold the first sample across a dropped completion.
        sample_ready = 1'b0;
        mic_word = 24'hC3C3C3;
        wait_valid("bp_valid", 600, rel);
        check("bp_first_sample", 32'(sample), 32'h0000C3C3);
        mic_word = 24'h3C3C3C;
        stable = 1'b1;
        n = 0;
        while (!overrun && n < 700) begin
            tick();
            n++;
            stable = stable && sample_valid && (sample == 16'hC3C3);
        end
        check("bp_overrun_set", 32'(overrun), 32'd1);
        check("bp_overrun_interval", 32'(n), 32'd512);
        check("bp_held_stable", 32'(stable), 32'd1);
        check("bp_sample_after_drop", 32'(sample), 32'h0000C3C3);
        sample_ready = 1'b1;
        tick();
        check("bp_transfer_valid", 32'(sample_valid), 32'd0);
        check("bp_overrun_sticky", 32'(overrun), 32'd1);
        wait_valid("bp_next_valid", 600, rel);
        check("bp_next_sample", 32'(sample), 32'h00003C3C);
        check("bp_overrun_still", 32'(overrun), 32'd1);
        tick();

        // Abort with en while a sample is pending, then re-enable.
        sample_ready = 1'b0;
        wait_valid("en_abort_valid", 600, rel);
        wait_slot10("en_abort_slot");
        check("en_abort_pending", 32'(sample_valid), 32'd1);
        en = 1'b0;
        tick();
        check("en_abort_sck", 32'(mic_sck), 32'd0);
        check("en_abort_ws", 32'(mic_ws), 32'd0);
        check("en_abort_valid_clr", 32'(sample_valid), 32'd0);
        check("en_abort_overrun_clr", 32'(overrun), 32'd0);
        tick();
        mic_word = 24'hA5F00F;
        sample_ready = 1'b1;
        en = 1'b1;
        wait_valid("en_restart_valid", 1000, rel);
        check("en_restart_latency", 32'(rel), 32'(FIRST_LAT));
        check("en_restart_sample", 32'(sample), 32'h0000A5F0);
        tick();

        // Abort with rst_n mid-frame; en stays high through the reset.
        sample_ready = 1'b0;
        wait_valid("rst_abort_valid", 600, rel);
        wait_slot10("rst_abort_slot");
        rst_n = 1'b0;
        tick();
        check("rst_abort_sck", 32'(mic_sck), 32'd0);
        check("rst_abort_valid", 32'(sample_valid), 32'd0);
        check("rst_abort_sample", 32'(sample), 32'd0);
        tick();
        tick();
        sample_ready = 1'b1;
        rst_n = 1'b1;
        wait_valid("rst_restart_valid", 1000, rel);
        check("rst_restart_latency", 32'(rel), 32'(FIRST_LAT));
        check("rst_restart_sample", 32'(sample), 32'h0000A5F0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
